// File: rtl/ws2812_drv.sv
// ws2812_drv: serializer for a chain of WS2812 LEDs.
// A one-cycle frame_start request starts a frame. The line is first held low
// for RST_CYC cycles so the LEDs latch. Then PIX_NUM pixels of 24 bits each are
// sent. Each bit lasts CLK_BIT cycles and is high for T0H or T1H cycles.
//
// Ports:
//   sys_clk     - single clock; all logic is rising-edge
//   sys_rst_n   - asynchronous, active-low reset
//   frame_start - one-cycle request; accepted only in IDLE
//   bit_in      - current GRB data bit, produced combinationally by the
//                 pixel-data stage from cnt_bit/cnt_pixel (named bit_in
//                 because "bit" is a reserved word in SystemVerilog)
//   cnt_bit     - bit index within the current pixel, 0..23
//   cnt_pixel   - pixel index, 0..PIX_NUM-1
//   dout        - registered WS2812 serial line
//   busy        - high from the accepted frame_start until frame_done
//   frame_done  - one-cycle pulse after the last bit of a frame
module ws2812_drv #(
  parameter int CLK_BIT = 62,
  parameter int T0H     = 20,
  parameter int T1H     = 40,
  parameter int RST_CYC = 15000,
  parameter int PIX_NUM = 64
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       frame_start,
  input  logic       bit_in,
  output logic [4:0] cnt_bit,
  output logic [6:0] cnt_pixel,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);

  // One cycle counter serves both the latch gap and the bit period.
  localparam int CYC_MAX = (RST_CYC > CLK_BIT) ? RST_CYC : CLK_BIT;
  localparam int CW      = $clog2(CYC_MAX + 1);

  typedef enum logic [1:0] {IDLE, LATCH, DATA} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_cyc_q, cnt_cyc_d;
  logic [4:0]    cnt_bit_q, cnt_bit_d;
  logic [6:0]    cnt_pixel_q, cnt_pixel_d;
  logic          bit_lat_q, bit_lat_d;
  logic          dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          cur_bit;
  logic [CW-1:0] thigh;
  logic          cyc_wrap, bit_wrap, pix_wrap;

  always_comb begin
    // In the first cycle of a bit the latch still holds the previous bit.
    // The live input is used there, and the latched copy is used afterwards.
    // After the first cycle, changes on bit_in cannot alter the waveform.
    cur_bit  = (cnt_cyc_q == '0) ? bit_in : bit_lat_q;
    thigh    = cur_bit ? CW'(T1H) : CW'(T0H);
    cyc_wrap = (cnt_cyc_q == CW'(CLK_BIT - 1));
    bit_wrap = (cnt_bit_q == 5'd23);
    pix_wrap = (cnt_pixel_q == 7'(PIX_NUM - 1));

    state_d     = state_q;
    cnt_cyc_d   = cnt_cyc_q;
    cnt_bit_d   = cnt_bit_q;
    cnt_pixel_d = cnt_pixel_q;
    bit_lat_d   = bit_lat_q;
    busy_d      = busy_q;
    dout_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ignore a request that arrives while frame_done is high, so that
        // the end of one frame cannot start the next one.
        if (frame_start && !done_q) begin
          state_d   = LATCH;
          busy_d    = 1'b1;
          cnt_cyc_d = '0;
        end
      end
      LATCH: begin
        if (cnt_cyc_q == CW'(RST_CYC - 1)) begin
          state_d   = DATA;
          cnt_cyc_d = '0;
        end else begin
          cnt_cyc_d = cnt_cyc_q + 1'b1;
        end
      end
      DATA: begin
        dout_d = (cnt_cyc_q < thigh);
        if (cnt_cyc_q == '0) begin
          bit_lat_d = bit_in;
        end
        if (cyc_wrap) begin
          cnt_cyc_d = '0;
          if (bit_wrap) begin
            cnt_bit_d = '0;
            if (pix_wrap) begin
              state_d     = IDLE;
              cnt_pixel_d = '0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
            end else begin
              cnt_pixel_d = cnt_pixel_q + 1'b1;
            end
          end else begin
            cnt_bit_d = cnt_bit_q + 1'b1;
          end
        end else begin
          cnt_cyc_d = cnt_cyc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_cyc_q   <= '0;
      cnt_bit_q   <= '0;
      cnt_pixel_q <= '0;
      bit_lat_q   <= 1'b0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_cyc_q   <= cnt_cyc_d;
      cnt_bit_q   <= cnt_bit_d;
      cnt_pixel_q <= cnt_pixel_d;
      bit_lat_q   <= bit_lat_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cnt_bit    = cnt_bit_q;
  assign cnt_pixel  = cnt_pixel_q;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ws2812_drv.sv
// tb_ws2812_drv: directed testbench for ws2812_drv with small parameters
// (CLK_BIT=10, T0H=3, T1H=7, RST_CYC=20, PIX_NUM=2).
// Cycle k counts the clock edges after the edge that accepted frame_start:
//   LATCH occupies k=1..20, DATA occupies k=21..500, and frame_done is high at k=501.
// dout seen after edge k reflects DATA cycle j=k-22.
module tb_ws2812_drv;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       frame_start;
  logic       bit_in;
  logic [4:0] cnt_bit;
  logic [6:0] cnt_pixel;
  logic       dout;
  logic       busy;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  ws2812_drv #(
    .CLK_BIT(10), .T0H(3), .T1H(7), .RST_CYC(20), .PIX_NUM(2)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .frame_start(frame_start),
    .bit_in     (bit_in),
    .cnt_bit    (cnt_bit),
    .cnt_pixel  (cnt_pixel),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Hand-computed checkpoints within a frame, selected by data mode.
  typedef struct {
    int         mode;
    int         k;
    logic       dout;
    logic       busy;
    logic       done;
    logic [4:0] cb;
    logic [6:0] cp;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Data-stage model. Mode 1 sends all ones. Mode 2 sends ones on even
  // cnt_bit. Mode 3 sends 0 at the start of each bit and toggles mid-bit.
  task automatic applyStimulus(input int mode, input int j);
    if (j < 0 || j >= 480) bit_in = (mode == 1);
    else if (mode == 1)    bit_in = 1'b1;
    else if (mode == 2)    bit_in = (((j / 10) % 24) % 2 == 0);
    else                   bit_in = logic'((j % 10) % 2);
  endtask

  function automatic logic expDout(input int mode, input int k);
    int jp;
    int th;
    jp = k - 22;
    if (jp < 0 || jp >= 480) return 1'b0;
    if (mode == 1)      th = 7;
    else if (mode == 2) th = (((jp / 10) % 24) % 2 == 0) ? 7 : 3;
    else                th = 3;
    return ((jp % 10) < th);
  endfunction

  task automatic checkCycle(input int mode, input int k);
    logic       e_busy;
    logic [4:0] e_cb;
    logic [6:0] e_cp;
    e_busy = (k >= 1 && k <= 500);
    e_cb   = (k >= 21 && k <= 500) ? 5'(((k - 21) / 10) % 24) : 5'd0;
    e_cp   = (k >= 21 && k <= 500) ? 7'((k - 21) / 240) : 7'd0;
    checkOutput($sformatf("dout m%0d k=%0d", mode, k), 32'(dout), 32'(expDout(mode, k)));
    checkOutput($sformatf("busy m%0d k=%0d", mode, k), 32'(busy), 32'(e_busy));
    checkOutput($sformatf("done m%0d k=%0d", mode, k), 32'(frame_done), 32'(k == 501));
    checkOutput($sformatf("cnt_bit m%0d k=%0d", mode, k), 32'(cnt_bit), 32'(e_cb));
    checkOutput($sformatf("cnt_pixel m%0d k=%0d", mode, k), 32'(cnt_pixel), 32'(e_cp));
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].mode == mode && vecs[i].k == k) begin
        checkOutput($sformatf("vec%0d dout", i), 32'(dout), 32'(vecs[i].dout));
        checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
        checkOutput($sformatf("vec%0d done", i), 32'(frame_done), 32'(vecs[i].done));
        checkOutput($sformatf("vec%0d cnt_bit", i), 32'(cnt_bit), 32'(vecs[i].cb));
        checkOutput($sformatf("vec%0d cnt_pixel", i), 32'(cnt_pixel), 32'(vecs[i].cp));
      end
    end
  endtask

  // Runs one frame and checks it cycle by cycle. The frame can re-request at
  // k=100, request during the frame_done cycle, or reset mid-DATA at abortAt.
  task automatic runFrame(input int mode, input int reassert, input int doneStart, input int abortAt);
    frame_start = 1'b1;
    applyStimulus(mode, -21);
    tick();
    frame_start = 1'b0;
    for (int k = 1; k <= 505; k++) begin
      checkCycle(mode, k);
      if (k == abortAt) begin
        #2 sys_rst_n = 1'b0;
        #1;
        checkOutput("abort dout", 32'(dout), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(frame_done), 32'd0);
        checkOutput("abort cnt_bit", 32'(cnt_bit), 32'd0);
        checkOutput("abort cnt_pixel", 32'(cnt_pixel), 32'd0);
        return;
      end
      frame_start = logic'((reassert != 0 && k == 100) || (doneStart != 0 && k == 501));
      applyStimulus(mode, k - 21);
      tick();
    end
    frame_start = 1'b0;
  endtask

  task automatic checkIdle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      checkOutput($sformatf("%s dout %0d", name, i), 32'(dout), 32'd0);
      checkOutput($sformatf("%s busy %0d", name, i), 32'(busy), 32'd0);
      checkOutput($sformatf("%s done %0d", name, i), 32'(frame_done), 32'd0);
      checkOutput($sformatf("%s cnt_bit %0d", name, i), 32'(cnt_bit), 32'd0);
      checkOutput($sformatf("%s cnt_pixel %0d", name, i), 32'(cnt_pixel), 32'd0);
    end
  endtask

  initial begin
    //                mode  k   dout busy done cb  cp
    vecs.push_back('{1,   1,   0,   1,   0,   0,  0});
    vecs.push_back('{1,  20,   0,   1,   0,   0,  0});
    vecs.push_back('{1,  21,   0,   1,   0,   0,  0});
    vecs.push_back('{1,  22,   1,   1,   0,   0,  0});
    vecs.push_back('{1,  28,   1,   1,   0,   0,  0});
    vecs.push_back('{1,  29,   0,   1,   0,   0,  0});
    vecs.push_back('{1,  31,   0,   1,   0,   1,  0});
    vecs.push_back('{1,  32,   1,   1,   0,   1,  0});
    vecs.push_back('{1, 261,   0,   1,   0,   0,  1});
    vecs.push_back('{1, 500,   0,   1,   0,  23,  1});
    vecs.push_back('{1, 501,   0,   0,   1,   0,  0});
    vecs.push_back('{1, 502,   0,   0,   0,   0,  0});
    vecs.push_back('{2,  28,   1,   1,   0,   0,  0});
    vecs.push_back('{2,  29,   0,   1,   0,   0,  0});
    vecs.push_back('{2,  34,   1,   1,   0,   1,  0});
    vecs.push_back('{2,  35,   0,   1,   0,   1,  0});
    vecs.push_back('{2,  42,   1,   1,   0,   2,  0});
    vecs.push_back('{3,  24,   1,   1,   0,   0,  0});
    vecs.push_back('{3,  25,   0,   1,   0,   0,  0});

    sys_rst_n   = 1'b0;
    frame_start = 1'b0;
    bit_in      = 1'b0;
    #1;
    checkOutput("reset dout", 32'(dout), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    tick();
    tick();
    sys_rst_n = 1'b1;

    $display("[TB] idle after reset");
    checkIdle("idle", 100);

    $display("[TB] frame, bit tied 1");
    runFrame(1, 0, 0, 0);

    $display("[TB] frame, alternating bits, extra requests");
    runFrame(2, 1, 1, 0);
    checkIdle("post-done", 20);

    $display("[TB] frame, mid-bit toggling");
    runFrame(3, 0, 0, 0);

    $display("[TB] reset mid-frame");
    runFrame(1, 0, 0, 145);
    tick();
    tick();
    sys_rst_n = 1'b1;
    checkIdle("after-abort", 600);

    $display("[TB] frame after abort");
    runFrame(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
